core_hazard_scoreboard: RTL
===========================

# core_hazard_scoreboard

Parametrised successor to the core's combinational hazard logic. Adds a registered per-register scoreboard for long-latency writers (divider, multiplier, uncached loads) so independent instructions keep issuing while they run. Generalises forwarding to N pipeline stages, and adds a stall-timeout watchdog and an outstanding-write counter. Sits beside the ID/EX stages and drives the same stall/flush/forward-select nets.

## Interface
Parameters:
- `NUM_REGS`, 32, architectural registers; register 0 is hard-wired zero.
- `REG_W`, $clog2(NUM_REGS), register index width.
- `FWD_STAGES`, 2, forwarding sources; index 0 is the youngest (MEM), the highest index is the oldest (WB).
- `NUM_UNITS`, 2, long-latency units able to own a register.
- `STALL_TIMEOUT`, 1024, consecutive scoreboard-stall cycles before the watchdog fires.

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset; synchronous, active-high
- `i_id_valid`  in  1  valid instruction in ID
- `i_id_rs1`, `i_id_rs2`, `i_id_rd`  in  REG_W  ID source/destination indices
- `i_ex_rs1`, `i_ex_rs2`, `i_ex_rd`  in  REG_W  EX indices
- `i_ex_is_load`  in  1  EX holds a short-latency (cache-hit path) load
- `i_fwd_rd`  in  FWD_STAGES*REG_W  destination per forwarding stage; slice k is stage k
- `i_fwd_regwrite`  in  FWD_STAGES  write enable per stage
- `i_issue_valid`  in  1  long-latency op committed to a unit this cycle
- `i_issue_rd`  in  REG_W  its destination
- `i_issue_unit`  in  $clog2(NUM_UNITS)  owning unit
- `i_done`  in  NUM_UNITS  unit k writes back this cycle
- `i_done_rd`  in  NUM_UNITS*REG_W  destination per unit
- `i_ext_stall`  in  1  OR of icache/dcache/UART stalls
- `i_redirect`  in  1  branch/jump/CSR redirect resolved in EX
- `o_fwda`, `o_fwdb`  out  $clog2(FWD_STAGES+1)  0 = register file; k = stage k-1
- `o_stall_if`, `o_stall_id`, `o_stall_ex`  out  1
- `o_flush_id`, `o_flush_ex`  out  1
- `o_pending_cnt`  out  $clog2(NUM_REGS+1)  registers currently owned
- `o_stall_timeout`  out  1  sticky watchdog flag

## Operation
Scoreboard:
- Each register r has a `pend[r]` bit and an owner tag `own[r]`.
- Issue sets `pend[rd]` and writes `own[rd] = unit`. Issue to rd=0 is ignored.
- `i_done[k]` clears `pend[i_done_rd[k]]` only if that register is pending and `own == k`. Mismatched or non-pending completions are ignored.
- Issue and done to the same rd in the same cycle: issue wins. The bit stays set and the new owner is recorded.
- Issue is non-flushable: the pipeline commits ops to units only past the redirect point.

Combinational checks:
- `clr(r)` is true when a valid, owner-matching done targets r this cycle.
- `busy(r) = pend[r] & !clr(r)`. A same-cycle completion releases the dependency with no extra stall.
- `sb_stall = i_id_valid & (busy(rs1) | busy(rs2) | busy(rd))`. Register 0 is never busy. The rd term enforces WAW ordering.
- `lu_stall = i_ex_is_load & i_ex_rd != 0 & (i_ex_rd == i_id_rs1 | i_ex_rd == i_id_rs2)`.

Forwarding:
- For each EX source, select the lowest stage k with `i_fwd_regwrite[k]`, `i_fwd_rd[k] == rs`, and `rs != 0`. Output k+1.
- Otherwise output 0.

Stall and flush outputs:
- `o_stall_if = o_stall_id = sb_stall | lu_stall | i_ext_stall`
- `o_stall_ex = i_ext_stall`
- `o_flush_ex = i_redirect | ((sb_stall | lu_stall) & !i_ext_stall)`, which inserts a bubble.
- `o_flush_id = i_redirect`
- Redirect overrides stall for the flush outputs. Scoreboard state is unaffected.

Counter and watchdog:
- `o_pending_cnt` is registered. It adds 1 on an accepted issue to a non-pending register and subtracts 1 per accepted clear, net per cycle.
- The watchdog counter increments while `sb_stall` and resets to 0 otherwise. It saturates at STALL_TIMEOUT.
- On reaching STALL_TIMEOUT it sets `o_stall_timeout`, which holds until reset.

## Timing
- Reset state: all `pend` = 0, owners 0, `o_pending_cnt` = 0, watchdog counter 0, `o_stall_timeout` = 0.
- During reset, all combinational outputs follow the cleared state: forward selects 0, and stalls and flushes are driven only by the inputs.
- Scoreboard updates take effect at the clock edge. An ID read of rd in the cycle right after issue sees it busy.
- Stall and forward outputs are purely combinational from the inputs plus registered state, with zero latency.
- Reset asserted mid-operation discards all ownership. Later `i_done` pulses for old ops are ignored.

## Test plan
- Issue rd=5 on unit 0; ID reads rs1=5 for 3 cycles, then `i_done[0]` with rd=5. Required: stall for 3 cycles, no stall in the done cycle, `o_pending_cnt` 1 → 0.
- Unit 1 issues rd=5 and then unit 0 signals done for rd=5. Required: ignored, bit remains set. Then unit 1 done clears it.
- Issue and done for rd=7 in the same cycle. Required: pend[7] stays 1, count unchanged.
- Forwarding with FWD_STAGES=3, stages 0 and 2 both writing rd=3 and EX rs2=3. Required: `o_fwdb` = 1. With rs2=0: `o_fwdb` = 0.
- Load-use (ex_rd=4, id_rs1=4) together with `i_redirect`. Required: `o_flush_ex` = 1, `o_flush_id` = 1, stall_if = 1. With `i_ext_stall` and no redirect: `o_flush_ex` = 0.
- Hold a dependency for STALL_TIMEOUT cycles. Required: `o_stall_timeout` rises exactly on cycle STALL_TIMEOUT, stays high after done, and clears only on `i_rst`.

Source files
------------

// File: rtl/core_hazard_scoreboard.sv
// Hazard unit: registered per-register scoreboard for long-latency writers,
// N-stage forwarding select, load-use/stall/flush generation and a stall watchdog.
module core_hazard_scoreboard #(
    parameter int NUM_REGS      = 32,
    parameter int REG_W         = $clog2(NUM_REGS),
    parameter int FWD_STAGES    = 2,
    parameter int NUM_UNITS     = 2,
    parameter int STALL_TIMEOUT = 1024,
    localparam int UNIT_W       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
    localparam int SEL_W        = $clog2(FWD_STAGES + 1),
    localparam int CNT_W        = $clog2(NUM_REGS + 1)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_id_valid,
    input  logic [REG_W-1:0]              i_id_rs1,
    input  logic [REG_W-1:0]              i_id_rs2,
    input  logic [REG_W-1:0]              i_id_rd,
    input  logic [REG_W-1:0]              i_ex_rs1,
    input  logic [REG_W-1:0]              i_ex_rs2,
    input  logic [REG_W-1:0]              i_ex_rd,
    input  logic                          i_ex_is_load,
    input  logic [FWD_STAGES*REG_W-1:0]   i_fwd_rd,
    input  logic [FWD_STAGES-1:0]         i_fwd_regwrite,
    input  logic                          i_issue_valid,
    input  logic [REG_W-1:0]              i_issue_rd,
    input  logic [UNIT_W-1:0]             i_issue_unit,
    input  logic [NUM_UNITS-1:0]          i_done,
    input  logic [NUM_UNITS*REG_W-1:0]    i_done_rd,
    input  logic                          i_ext_stall,
    input  logic                          i_redirect,
    output logic [SEL_W-1:0]              o_fwda,
    output logic [SEL_W-1:0]              o_fwdb,
    output logic                          o_stall_if,
    output logic                          o_stall_id,
    output logic                          o_stall_ex,
    output logic                          o_flush_id,
    output logic                          o_flush_ex,
    output logic [CNT_W-1:0]              o_pending_cnt,
    output logic                          o_stall_timeout
);

    localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

    logic [NUM_REGS-1:0] r_pend;
    logic [UNIT_W-1:0]   r_own [NUM_REGS];
    logic [CNT_W-1:0]    r_pending_cnt;
    logic [WD_W-1:0]     r_wd_cnt;
    logic                r_stall_timeout;

    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_pend_next;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [WD_W-1:0]     w_wd_next;
    logic                w_issue;
    logic                w_sb_stall;
    logic                w_lu_stall;
    logic [SEL_W-1:0]    w_fwda;
    logic [SEL_W-1:0]    w_fwdb;
    logic                w_found_a;
    logic                w_found_b;

    assign w_issue = i_issue_valid && (i_issue_rd != '0);

    // A completion only counts when it comes from the unit that currently owns the register.
    always_comb begin
        w_clr = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            for (int unsigned k = 0; k < NUM_UNITS; k++) begin
                if (i_done[k] && (i_done_rd[k*REG_W +: REG_W] == REG_W'(r)) &&
                    r_pend[r] && (r_own[r] == UNIT_W'(k))) begin
                    w_clr[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_busy    = r_pend & ~w_clr & {NUM_REGS{~i_rst}};
        w_busy[0] = 1'b0;
    end

    assign w_sb_stall = i_id_valid &&
                        (w_busy[i_id_rs1] || w_busy[i_id_rs2] || w_busy[i_id_rd]);
    assign w_lu_stall = i_ex_is_load && (i_ex_rd != '0) &&
                        ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

    // Youngest matching stage wins; the first hit in ascending order is kept.
    always_comb begin
        w_fwda    = '0;
        w_fwdb    = '0;
        w_found_a = 1'b0;
        w_found_b = 1'b0;
        for (int unsigned k = 0; k < FWD_STAGES; k++) begin
            if (!w_found_a && !i_rst && i_fwd_regwrite[k] && (i_ex_rs1 != '0) &&
                (i_fwd_rd[k*REG_W +: REG_W] == i_ex_rs1)) begin
                w_fwda    = SEL_W'(k + 1);
                w_found_a = 1'b1;
            end
            if (!w_found_b && !i_rst && i_fwd_regwrite[k] && (i_ex_rs2 != '0) &&
                (i_fwd_rd[k*REG_W +: REG_W] == i_ex_rs2)) begin
                w_fwdb    = SEL_W'(k + 1);
                w_found_b = 1'b1;
            end
        end
    end

    // Issue overrides a same-cycle clear; the count tracks the resulting pending set.
    always_comb begin
        w_pend_next = r_pend & ~w_clr;
        if (w_issue) begin
            w_pend_next[i_issue_rd] = 1'b1;
        end
        w_cnt_next = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            w_cnt_next = w_cnt_next + CNT_W'(w_pend_next[r]);
        end
    end

    always_comb begin
        if (!w_sb_stall) begin
            w_wd_next = '0;
        end else if (r_wd_cnt == WD_W'(STALL_TIMEOUT)) begin
            w_wd_next = r_wd_cnt;
        end else begin
            w_wd_next = r_wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pend          <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                r_own[r] <= '0;
            end
            r_pending_cnt   <= '0;
            r_wd_cnt        <= '0;
            r_stall_timeout <= 1'b0;
        end else begin
            r_pend <= w_pend_next;
            if (w_issue) begin
                r_own[i_issue_rd] <= i_issue_unit;
            end
            r_pending_cnt   <= w_cnt_next;
            r_wd_cnt        <= w_wd_next;
            r_stall_timeout <= r_stall_timeout ||
                               (w_sb_stall && (w_wd_next == WD_W'(STALL_TIMEOUT)));
        end
    end

    assign o_fwda          = w_fwda;
    assign o_fwdb          = w_fwdb;
    assign o_stall_if      = w_sb_stall || w_lu_stall || i_ext_stall;
    assign o_stall_id      = w_sb_stall || w_lu_stall || i_ext_stall;
    assign o_stall_ex      = i_ext_stall;
    assign o_flush_id      = i_redirect;
    assign o_flush_ex      = i_redirect || ((w_sb_stall || w_lu_stall) && !i_ext_stall);
    assign o_pending_cnt   = r_pending_cnt;
    assign o_stall_timeout = r_stall_timeout;

endmodule
